button_event_detector: RTL
==========================

# button_event_detector

Classifies the clean, debounced button level produced by the debouncer stage into single-cycle user events: press, release, short press, long press and double click. Sits directly downstream of the debouncer, with its input wired to the debouncer output. Its registered event pulses feed control logic in the same clock domain.

## Interface
- long_press_cycles, default 50: cycles a press must be held, counted from press_pulse, to be classed as long; must be >= 2.
- dbl_click_window, default 20: cycles after release_pulse during which a new press counts as the second click; must be >= 2.
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- debounced_in  input  1  debounced button level; already synchronous to clk.
- held  output  1  registered copy of debounced_in.
- press_pulse  output  1  one-cycle pulse on an accepted press.
- release_pulse  output  1  one-cycle pulse on an accepted release.
- short_press  output  1  one-cycle pulse for a completed single short click.
- long_press  output  1  one-cycle pulse when the long-press threshold is reached.
- double_click  output  1  one-cycle pulse for a completed double click.

## Operation
- Edge detect compares debounced_in with registered sample in_q: rise = debounced_in & ~in_q, fall = ~debounced_in & in_q.
- An armed flag is cleared by reset. The first edge after reset loads in_q and sets armed, and produces no rise or fall. A button held through reset therefore generates no events until it is released and pressed again.
- One shared counter cnt, width $clog2(max(long_press_cycles, dbl_click_window)+1). It is cleared on every state change and never wraps.
- FSM states: IDLE, PRESSED, LONG_HELD, WAIT_SECOND, SECOND_PRESSED.
- IDLE: on rise, pulse press_pulse and go to PRESSED.
- PRESSED:
  - fall: pulse release_pulse and go to WAIT_SECOND.
  - else, if cnt == long_press_cycles-1: pulse long_press and go to LONG_HELD.
  - else increment cnt.
- LONG_HELD: on fall, pulse release_pulse and go to IDLE. No short_press or double_click is issued.
- WAIT_SECOND:
  - rise: pulse press_pulse and go to SECOND_PRESSED.
  - else, if cnt == dbl_click_window-1: pulse short_press and go to IDLE.
  - else increment cnt.
- SECOND_PRESSED:
  - fall: pulse release_pulse and double_click together, then go to IDLE.
  - else, if cnt == long_press_cycles-1: pulse long_press and go to LONG_HELD. The first click is discarded and no short_press is issued.
  - else increment cnt.
- Priority: fall beats the long threshold in the same cycle, and rise beats window expiry.
- Event outputs are mutually exclusive in any cycle, except release_pulse with double_click.

## Timing
- Reset values: all outputs 0, in_q 0, armed 0, state IDLE, cnt 0.
- Reset mid-operation takes effect at the next edge: the FSM returns to IDLE and no pending short_press, long_press or double_click is emitted.
- All outputs are registered. An input change sampled at edge E is reflected in outputs after edge E, giving 1-cycle latency. Every pulse lasts exactly one cycle.
- long_press is asserted exactly long_press_cycles cycles after press_pulse, provided the button is still held.
- short_press is asserted exactly dbl_click_window cycles after release_pulse.
- A second click is accepted if its rise is sampled 1 to dbl_click_window cycles after the release_pulse cycle.
- held follows debounced_in with 1-cycle delay, including while unarmed.

## Structure
- Shared package btn_evt_pkg: the state_t enum (IDLE, PRESSED, LONG_HELD, WAIT_SECOND, SECOND_PRESSED) and a helper for the counter-width calculation.
- One sub-module, edge_detect: in_q, armed, rise and fall outputs. The FSM and counter live in the top of button_event_detector.

## Test plan
All scenarios use long_press_cycles=5 and dbl_click_window=4.
- Tap: input high 2 cycles then low -> press_pulse 1 cycle after rise, release_pulse 1 cycle after fall, short_press 4 cycles after release_pulse; no long_press or double_click.
- Long hold: input high 10 cycles -> long_press 5 cycles after press_pulse, release_pulse after fall; no short_press.
- Fall on threshold: input high for exactly 5 cycles -> fall wins, release_pulse with no long_press, then short_press 4 cycles later.
- Double click and window boundary:
  - high 2, low 2, high 2, low -> 2 press_pulse, double_click coincident with the second release_pulse, no short_press.
  - Repeat with the second rise sampled 4 cycles after release_pulse -> double_click.
  - Repeat with the second rise sampled 5 cycles after release_pulse -> short_press first, then an independent new press.
- Held through reset: input 1 during rst and for 6 cycles after -> no pulses; then low then high -> normal press_pulse.
- Reset mid-WAIT_SECOND: tap, assert rst 2 cycles after release_pulse -> all outputs 0, no short_press ever issued.

Source files
------------

// File: rtl/btn_evt_pkg.sv
// Shared types for the button event detector: FSM state encoding and the
// counter-width helper used to size the shared hold/window counter.
// No ports; imported by button_event_detector.
package btn_evt_pkg;

  typedef enum logic [2:0] {
    IDLE           = 3'd0,
    PRESSED        = 3'd1,
    LONG_HELD      = 3'd2,
    WAIT_SECOND    = 3'd3,
    SECOND_PRESSED = 3'd4
  } state_t;

  // Bits needed to hold any value 0..max(a, b).
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/edge_detect.sv
// Purpose: rise/fall detector on the debounced level, muted until the first
//   sample after reset so a button held through reset produces no edge.
// Latency: combinational rise_o/fall_o against the registered sample in_q.
// Backpressure: none; free-running every cycle.
// Ports: clk_i, rst_i (sync, active-high), in_i level -> rise_o, fall_o.
module edge_detect (
  input  logic clk_i,
  input  logic rst_i,
  input  logic in_i,
  output logic rise_o,
  output logic fall_o
);

  logic in_q;
  logic armed_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      in_q    <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      in_q    <= in_i;
      armed_q <= 1'b1;
    end
  end

  // Unarmed, in_q still holds its reset value, so edges are suppressed
  // until in_q has captured a real sample.
  assign rise_o = armed_q &  in_i & ~in_q;
  assign fall_o = armed_q & ~in_i &  in_q;

endmodule

// File: rtl/button_event_detector.sv
// Purpose: classify debounced button level into press/release/short/long/
//   double-click single-cycle pulses.
// Latency: 1 cycle from sampled input change to registered output pulse.
// Backpressure: none; pulses are fire-and-forget, every cycle.
// Ports: clk, rst (sync, active-high), debounced_in -> held, press_pulse,
//   release_pulse, short_press, long_press, double_click.
module button_event_detector
  import btn_evt_pkg::*;
#(
  parameter int long_press_cycles = 50,
  parameter int dbl_click_window  = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic debounced_in,
  output logic held,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_press,
  output logic long_press,
  output logic double_click
);

  localparam int CW = cnt_width(long_press_cycles, dbl_click_window);
  localparam logic [CW-1:0] LONG_LAST = CW'(long_press_cycles - 1);
  localparam logic [CW-1:0] WIN_LAST  = CW'(dbl_click_window - 1);

  logic rise, fall;

  edge_detect u_edge_detect (
    .clk_i  (clk),
    .rst_i  (rst),
    .in_i   (debounced_in),
    .rise_o (rise),
    .fall_o (fall)
  );

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            held_q;
  logic            press_q, press_d;
  logic            release_q, release_d;
  logic            short_q, short_d;
  logic            long_q, long_d;
  logic            dbl_q, dbl_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      held_q    <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      short_q   <= 1'b0;
      long_q    <= 1'b0;
      dbl_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      held_q    <= debounced_in;
      press_q   <= press_d;
      release_q <= release_d;
      short_q   <= short_d;
      long_q    <= long_d;
      dbl_q     <= dbl_d;
    end
  end

  // Edges take priority over the counter thresholds in every state; the
  // counter is zeroed on each transition and only counts below its limit.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    short_d   = 1'b0;
    long_d    = 1'b0;
    dbl_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rise) begin
          press_d = 1'b1;
          state_d = PRESSED;
          cnt_d   = '0;
        end
      end
      PRESSED: begin
        if (fall) begin
          release_d = 1'b1;
          state_d   = WAIT_SECOND;
          cnt_d     = '0;
        end else if (cnt_q == LONG_LAST) begin
          long_d  = 1'b1;
          state_d = LONG_HELD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      LONG_HELD: begin
        if (fall) begin
          release_d = 1'b1;
          state_d   = IDLE;
          cnt_d     = '0;
        end
      end
      WAIT_SECOND: begin
        if (rise) begin
          press_d = 1'b1;
          state_d = SECOND_PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == WIN_LAST) begin
          short_d = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      SECOND_PRESSED: begin
        if (fall) begin
          release_d = 1'b1;
          dbl_d     = 1'b1;
          state_d   = IDLE;
          cnt_d     = '0;
        end else if (cnt_q == LONG_LAST) begin
          // Held too long for a double click: first click is dropped.
          long_d  = 1'b1;
          state_d = LONG_HELD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign held          = held_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign short_press   = short_q;
  assign long_press    = long_q;
  assign double_click  = dbl_q;

endmodule
